// File: rtl/mem_arb_pkg.sv
// Shared encodings and defaults for the fetch/data SRAM arbiter.
package mem_arb_pkg;
   typedef logic [1:0] owner_t;

   localparam owner_t OWN_NONE = 2'd0;
   localparam owner_t OWN_I    = 2'd1;
   localparam owner_t OWN_D    = 2'd2;

   localparam int STRB_W             = 4;
   localparam int MAX_STREAK_DEFAULT = 4;
endpackage

// File: rtl/arb_streak_ctr.sv
// Saturating count of consecutive data grants taken while fetch was waiting.
module arb_streak_ctr
   import mem_arb_pkg::*;
#(
   parameter int LIMIT = MAX_STREAK_DEFAULT
) (
   input  logic clk,
   input  logic rst,
   input  logic inc,
   input  logic clr,
   output logic starve
);
   localparam logic [3:0] LIMIT_C = 4'(LIMIT);

   logic [3:0] count_d;
   logic [3:0] count_q;

   always_comb begin
      count_d = count_q;
      if (clr) begin
         count_d = 4'd0;
      end else if (inc && (count_q < LIMIT_C)) begin
         count_d = count_q + 4'd1;
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         count_q <= 4'd0;
      end else begin
         count_q <= count_d;
      end
   end

   assign starve = (count_q >= LIMIT_C);
endmodule

// File: rtl/mem_arbiter.sv
// Shares one single-port word SRAM between instruction fetch and data access,
// routing the 1-cycle read data back to whichever port issued the read.
module mem_arbiter
   import mem_arb_pkg::*;
#(
   parameter int ADDR_W     = 10,
   parameter int MAX_STREAK = MAX_STREAK_DEFAULT
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              i_req,
   input  logic [31:0]       i_addr,
   output logic              i_gnt,
   output logic              i_rvalid,
   output logic [31:0]       i_rdata,
   input  logic              d_req,
   input  logic              d_we,
   input  logic [31:0]       d_addr,
   input  logic [31:0]       d_wdata,
   input  logic [STRB_W-1:0] d_wstrobe,
   output logic              d_gnt,
   output logic              d_rvalid,
   output logic [31:0]       d_rdata,
   output logic              m_en,
   output logic [STRB_W-1:0] m_we,
   output logic [ADDR_W-1:0] m_addr,
   output logic [31:0]       m_wdata,
   input  logic [31:0]       m_rdata
);
   logic        starve;
   logic        i_win;
   logic        d_win;
   logic [31:0] sel_addr;
   logic        unused_addr_bits;
   owner_t      owner_d;
   owner_t      owner_q;

   // Data wins contention until fetch has been starved for MAX_STREAK grants.
   always_comb begin
      d_win = d_req && (!i_req || !starve);
      i_win = i_req && !d_win;
   end

   assign d_gnt = d_win && !rst;
   assign i_gnt = i_win && !rst;

   arb_streak_ctr #(
      .LIMIT (MAX_STREAK)
   ) u_streak (
      .clk    (clk),
      .rst    (rst),
      .inc    (d_gnt && i_req),
      .clr    (i_gnt || !i_req),
      .starve (starve)
   );

   assign sel_addr         = d_gnt ? d_addr : i_addr;
   assign m_addr           = sel_addr[ADDR_W+1:2];
   assign unused_addr_bits = ^{sel_addr[31:ADDR_W+2], sel_addr[1:0]};
   assign m_en             = i_gnt || d_gnt;
   assign m_we             = (d_gnt && d_we) ? d_wstrobe : '0;
   assign m_wdata          = d_wdata;

   // Writes return nothing, so only reads record an owner for the next cycle.
   always_comb begin
      owner_d = OWN_NONE;
      if (i_gnt) begin
         owner_d = OWN_I;
      end else if (d_gnt && !d_we) begin
         owner_d = OWN_D;
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         owner_q <= OWN_NONE;
      end else begin
         owner_q <= owner_d;
      end
   end

   // Gating with rst keeps a read that was in flight at reset from surfacing.
   assign i_rvalid = (owner_q == OWN_I) && !rst;
   assign d_rvalid = (owner_q == OWN_D) && !rst;
   assign i_rdata  = m_rdata;
   assign d_rdata  = m_rdata;
endmodule

// File: tb/tb_mem_arbiter.sv
// Randomised and directed bench for mem_arbiter against a transaction-level model.
module tb_mem_arbiter;
   localparam int ADDR_W     = 10;
   localparam int MAX_STREAK = 4;
   localparam int DEPTH      = 1 << ADDR_W;

   logic              clk = 1'b0;
   logic              rst;
   logic              i_req;
   logic [31:0]       i_addr;
   logic              i_gnt;
   logic              i_rvalid;
   logic [31:0]       i_rdata;
   logic              d_req;
   logic              d_we;
   logic [31:0]       d_addr;
   logic [31:0]       d_wdata;
   logic [3:0]        d_wstrobe;
   logic              d_gnt;
   logic              d_rvalid;
   logic [31:0]       d_rdata;
   logic              m_en;
   logic [3:0]        m_we;
   logic [ADDR_W-1:0] m_addr;
   logic [31:0]       m_wdata;
   logic [31:0]       m_rdata;

   int n_tests = 0;
   int n_fail  = 0;

   always #5 clk = ~clk;

   mem_arbiter #(
      .ADDR_W     (ADDR_W),
      .MAX_STREAK (MAX_STREAK)
   ) dut (
      .clk       (clk),
      .rst       (rst),
      .i_req     (i_req),
      .i_addr    (i_addr),
      .i_gnt     (i_gnt),
      .i_rvalid  (i_rvalid),
      .i_rdata   (i_rdata),
      .d_req     (d_req),
      .d_we      (d_we),
      .d_addr    (d_addr),
      .d_wdata   (d_wdata),
      .d_wstrobe (d_wstrobe),
      .d_gnt     (d_gnt),
      .d_rvalid  (d_rvalid),
      .d_rdata   (d_rdata),
      .m_en      (m_en),
      .m_we      (m_we),
      .m_addr    (m_addr),
      .m_wdata   (m_wdata),
      .m_rdata   (m_rdata)
   );

   function automatic logic [31:0] merge_bytes(logic [31:0] old_w, logic [31:0] new_w,
                                               logic [3:0] strb);
      logic [31:0] r;
      r = old_w;
      for (int b = 0; b < 4; b++) begin
         if (strb[b]) r[8*b +: 8] = new_w[8*b +: 8];
      end
      return r;
   endfunction

   // Behavioural SRAM macro: byte-masked write, registered read.
   logic [31:0] sram [0:DEPTH-1];
   always @(posedge clk) begin
      if (m_en) begin
         if (m_we == 4'b0000) m_rdata <= sram[m_addr];
         else                 sram[m_addr] <= merge_bytes(sram[m_addr], m_wdata, m_we);
      end
   end

   // Reference model state
   logic [31:0] ref_mem [0:DEPTH-1];
   int          streak;
   int          pend;       // 0 none, 1 fetch, 2 data
   logic [31:0] pend_data;
   bit          last_gi;
   bit          last_gd;
   bit          obs_dg;

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_tests++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", tag, got, exp, $time);
      end
   endtask

   function automatic int word_of(logic [31:0] a);
      return int'((a >> 2) & 32'(DEPTH - 1));
   endfunction

   task automatic set_req(input bit ir, input logic [31:0] ia, input bit dr, input bit dwe,
                          input logic [31:0] da, input logic [31:0] wd, input logic [3:0] ws);
      i_req = ir; i_addr = ia; d_req = dr; d_we = dwe;
      d_addr = da; d_wdata = wd; d_wstrobe = ws;
   endtask

   // One clock: predict, check mid-cycle, advance the model, move past the edge.
   task automatic cycle();
      bit         eg_i;
      bit         eg_d;
      logic [3:0] exp_we;
      int         w;
      eg_i = 1'b0;
      eg_d = 1'b0;
      if (!rst && d_req && (!i_req || streak < MAX_STREAK)) eg_d = 1'b1;
      else if (!rst && i_req) eg_i = 1'b1;
      exp_we = (eg_d && d_we) ? d_wstrobe : 4'b0000;
      w = eg_d ? word_of(d_addr) : word_of(i_addr);
      @(negedge clk);
      obs_dg = d_gnt;
      check("gnt_en_we", 32'({i_gnt, d_gnt, m_en, m_we}),
            32'({eg_i, eg_d, eg_i | eg_d, exp_we}));
      if (eg_i || eg_d) check("m_addr", 32'(m_addr), 32'(w));
      if (eg_d && d_we) check("m_wdata", m_wdata, d_wdata);
      check("rvalid", 32'({i_rvalid, d_rvalid}),
            32'({pend == 1 && !rst, pend == 2 && !rst}));
      if (pend == 1 && !rst) check("i_rdata", i_rdata, pend_data);
      if (pend == 2 && !rst) check("d_rdata", d_rdata, pend_data);
      if (rst) begin
         pend   = 0;
         streak = 0;
      end else begin
         pend = 0;
         if (eg_i) begin
            pend = 1; pend_data = ref_mem[w];
         end else if (eg_d && !d_we) begin
            pend = 2; pend_data = ref_mem[w];
         end else if (eg_d) begin
            ref_mem[w] = merge_bytes(ref_mem[w], d_wdata, d_wstrobe);
         end
         if (eg_i || !i_req) streak = 0;
         else if (eg_d && streak < MAX_STREAK) streak++;
      end
      last_gi = eg_i;
      last_gd = eg_d;
      @(posedge clk);
      #1;
   endtask

   function automatic logic [31:0] rand_addr();
      return ($urandom & 32'hFFFF_F000) | (32'($urandom_range(0, 15)) << 2) |
             ($urandom & 32'h3);
   endfunction

   initial begin
      logic [9:0] pat10;
      logic [5:0] pat6;
      for (int k = 0; k < DEPTH; k++) begin
         sram[k]    = (32'(k) * 32'h9E37_79B1) ^ 32'hA5A5_0000;
         ref_mem[k] = sram[k];
      end
      sram[4] = 32'hDEAD_BEEF; ref_mem[4] = 32'hDEAD_BEEF;
      streak = 0; pend = 0; pend_data = '0; last_gi = 0; last_gd = 0; obs_dg = 0;

      rst = 1'b1;
      set_req(0, 0, 0, 0, 0, 0, 4'b0000);
      @(posedge clk); #1;
      cycle();
      set_req(1, 32'h10, 1, 1, 32'h20, 32'hFFFF_FFFF, 4'b1111);
      cycle();
      rst = 1'b0;

      // Fetch read of word 4
      set_req(1, 32'h10, 0, 0, 0, 0, 4'b0000);
      cycle();
      set_req(0, 0, 0, 0, 0, 0, 4'b0000);
      cycle();
      check("fetch_deadbeef", pend_data, 32'hDEAD_BEEF);

      // Partial write to word 8, then read it back
      set_req(0, 0, 1, 1, 32'h20, 32'h1122_3344, 4'b0011);
      cycle();
      set_req(0, 0, 1, 0, 32'h20, 0, 4'b0000);
      cycle();
      set_req(0, 0, 0, 0, 0, 0, 4'b0000);
      cycle();
      check("partial_write", pend_data,
            {sram[3][31:16] ^ sram[3][31:16] ^ ((32'd8 * 32'h9E37_79B1) ^ 32'hA5A5_0000) >> 16,
             16'h3344});

      // Sustained contention: D,D,D,D,I repeating
      pat10 = 10'b1111011110;
      for (int k = 0; k < 10; k++) begin
         set_req(1, 32'h40, 1, 0, 32'h44, 0, 4'b0000);
         cycle();
         check("contend_pattern", 32'(obs_dg), 32'(pat10[9-k]));
      end

      // Back-to-back data reads
      for (int k = 0; k < 6; k++) begin
         set_req(0, 0, 1, 0, (k % 2 == 0) ? 32'h0 : 32'h4, 0, 4'b0000);
         cycle();
      end

      // Reset while a data read is in flight
      set_req(0, 0, 1, 0, 32'h10, 0, 4'b0000);
      cycle();
      rst = 1'b1;
      set_req(0, 0, 0, 0, 0, 0, 4'b0000);
      cycle();
      rst = 1'b0;
      cycle();

      // Streak clears when fetch drops its request
      set_req(1, 32'h8, 1, 0, 32'hC, 0, 4'b0000);
      cycle();
      cycle();
      set_req(0, 0, 1, 0, 32'hC, 0, 4'b0000);
      cycle();
      pat6 = 6'b111101;
      for (int k = 0; k < 6; k++) begin
         set_req(1, 32'h8, 1, 0, 32'hC, 0, 4'b0000);
         cycle();
         check("streak_clear", 32'(obs_dg), 32'(pat6[5-k]));
      end

      // Random traffic; ungranted requests are held stable
      for (int n = 0; n < 3000; n++) begin
         rst = ($urandom_range(0, 199) == 0);
         if (!(i_req && !last_gi)) begin
            i_req  = ($urandom_range(0, 2) != 0);
            i_addr = rand_addr();
         end
         if (!(d_req && !last_gd)) begin
            d_req     = ($urandom_range(0, 2) != 0);
            d_we      = ($urandom_range(0, 2) == 0);
            d_addr    = rand_addr();
            d_wdata   = $urandom;
            d_wstrobe = 4'($urandom);
         end
         cycle();
      end

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end
endmodule
